// File: rtl/pattern_generator_gen.sv
// Memory-BIST data-pattern generator: produces one registered gray/Euler, checkerboard, address or solid word per submit.
// Optional build macro PTRN_INVERT_EN adds inv_in, which complements the emitted word.
module pattern_generator_gen #(
  parameter int GW    = 5,
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int TSTEP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sbmt_in,
  input  logic          shft_in,
  input  logic [1:0]    mode_in,
  input  logic [AW-1:0] addr_in,
`ifdef PTRN_INVERT_EN
  input  logic          inv_in,
`endif
  output logic [DW-1:0] ptrn_out,
  output logic          ptrn_vld,
  output logic          seq_done
);

  localparam int CW = (GW > 1) ? $clog2(GW) : 1;

  logic [GW-1:0] count;
  logic [CW-1:0] selcnt;
  logic [CW-1:0] tilcnt;
  logic          cnt_last;
  logic          sel_last;
  logic          til_last;
  logic [DW-1:0] ptrn_nxt;

  // Euler column selcnt of the gray code, tiled across the word from phase tilcnt
  function automatic logic [DW-1:0] euler_tile(input logic [GW-1:0] cnt,
                                               input logic [CW-1:0] sel,
                                               input logic [CW-1:0] til);
    logic [GW-1:0] g;
    logic [GW-1:0] e;
    logic [DW-1:0] p;
    int            s;
    int            off;
    g   = cnt ^ (cnt >> 1);
    s   = int'(sel);
    off = int'(til) * TSTEP;
    for (int i = 0; i < GW; i++)
      e[i] = g[(i + s) % GW] ^ ((s != 0) && ((((i + s) % GW) == 0) || (i == 0)));
    for (int j = 0; j < DW; j++)
      p[DW-1-j] = e[(off + j) % GW];
    return p;
  endfunction

  function automatic logic [DW-1:0] checker_ptrn(input logic [AW-1:0] addr);
    logic [DW-1:0] p;
    for (int k = 0; k < DW; k++)
      p[k] = ((k % 2) == 1) ^ (^addr);
    return p;
  endfunction

  function automatic logic [DW-1:0] addr_ptrn(input logic [AW-1:0] addr, input logic ph);
    logic [DW+AW-1:0] ext;
    ext = {{DW{1'b0}}, addr};
    return ext[DW-1:0] ^ {DW{ph}};
  endfunction

  assign cnt_last = &count;
  assign sel_last = (selcnt == CW'(GW - 1));
  assign til_last = (tilcnt == CW'(GW - 1));

  always_comb begin
    ptrn_nxt = '0;
    case (mode_in)
      2'd0:    ptrn_nxt = euler_tile(count, selcnt, tilcnt);
      2'd1:    ptrn_nxt = checker_ptrn(addr_in);
      2'd2:    ptrn_nxt = addr_ptrn(addr_in, count[0]);
      default: ptrn_nxt = {DW{count[0]}};
    endcase
`ifdef PTRN_INVERT_EN
    ptrn_nxt = ptrn_nxt ^ {DW{inv_in}};
`endif
  end

  // Output register stage; counters advance after the pattern is captured
  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      selcnt   <= '0;
      tilcnt   <= '0;
      ptrn_out <= '0;
      ptrn_vld <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      ptrn_vld <= sbmt_in;
      seq_done <= sbmt_in && cnt_last && sel_last;
      if (sbmt_in) begin
        ptrn_out <= ptrn_nxt;
        count    <= count + 1'b1;
        if (cnt_last)
          selcnt <= sel_last ? '0 : selcnt + 1'b1;
      end
      if (shft_in)
        tilcnt <= til_last ? '0 : tilcnt + 1'b1;
    end
  end

endmodule
